// File: rtl/mac_cxu_l2.sv
// rtl/mac_cxu_l2.sv - CXU-L2 leaf target: per-state accumulators with iterative shift-add MAC
// Optional saturating MAC overflow detection: define MAC_CXU_L2_SAT_EN.
module mac_cxu_l2 #(
  parameter int CXU_N_STATES   = 4,
  parameter int CXU_STATE_ID_W = 2,
  parameter int CXU_FUNC_ID_W  = 10,
  parameter int CXU_INSN_W     = 0,
  parameter int CXU_DATA_W     = 32,
  parameter int CXU_STATUS_W   = 1,
  parameter int CXU_CXU_ID_W   = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      clk_en,
  input  logic                                      req_valid,
  output logic                                      req_ready,
  input  logic [CXU_CXU_ID_W-1:0]                   req_cxu,
  input  logic [CXU_STATE_ID_W-1:0]                 req_state,
  input  logic [CXU_FUNC_ID_W-1:0]                  req_func,
  input  logic [(CXU_INSN_W > 0 ? CXU_INSN_W : 1)-1:0] req_insn,
  input  logic [CXU_DATA_W-1:0]                     req_data0,
  input  logic [CXU_DATA_W-1:0]                     req_data1,
  output logic                                      resp_valid,
  input  logic                                      resp_ready,
  output logic [CXU_STATUS_W-1:0]                   resp_status,
  output logic [CXU_DATA_W-1:0]                     resp_data
);

  localparam int IDX_W = (CXU_N_STATES > 1) ? $clog2(CXU_N_STATES) : 1;
  localparam logic [CXU_STATE_ID_W:0] N_ST = (CXU_STATE_ID_W + 1)'(CXU_N_STATES);

  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, RESP = 2'd2} state_t;

  state_t                state;
  logic [CXU_DATA_W-1:0] acc [CXU_N_STATES];
  logic [IDX_W-1:0]      mul_idx;
  logic [CXU_DATA_W-1:0] mcand;
  logic [CXU_DATA_W-1:0] mplier;
  logic [CXU_DATA_W-1:0] partial;
  logic [CXU_DATA_W:0]   add_sum;
  logic [CXU_DATA_W:0]   acc_sum;
  logic [CXU_DATA_W-1:0] next_mplier;
  logic                  mul_done;
  logic                  accept;
  logic                  state_ok;
  logic [IDX_W-1:0]      req_idx;

  assign req_ready   = !rst && (state == IDLE || (state == RESP && resp_ready));
  assign accept      = clk_en && req_valid && req_ready;
  assign req_idx     = req_state[IDX_W-1:0];
  assign state_ok    = {1'b0, req_state} < N_ST;

  // One shift-add step; the step that empties the multiplier also folds into Acc.
  assign add_sum     = {1'b0, partial} + (mplier[0] ? {1'b0, mcand} : '0);
  assign next_mplier = mplier >> 1;
  assign mul_done    = (next_mplier == '0);
  assign acc_sum     = {1'b0, acc[mul_idx]} + {1'b0, add_sum[CXU_DATA_W-1:0]};

`ifdef MAC_CXU_L2_SAT_EN
  logic ovf;
  logic mac_ovf;
  // A multiplicand bit lost while multiplier bits remain would have landed above DATA_W.
  assign mac_ovf = ovf | add_sum[CXU_DATA_W] | (mcand[CXU_DATA_W-1] & !mul_done)
                 | (mul_done & acc_sum[CXU_DATA_W]);
`endif

  wire unused_ok = ^{req_cxu, req_insn, req_state, add_sum[CXU_DATA_W], acc_sum[CXU_DATA_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      resp_valid  <= 1'b0;
      resp_status <= '0;
      resp_data   <= '0;
      mul_idx     <= '0;
      mcand       <= '0;
      mplier      <= '0;
      partial     <= '0;
      for (int i = 0; i < CXU_N_STATES; i++) acc[i] <= '0;
`ifdef MAC_CXU_L2_SAT_EN
      ovf         <= 1'b0;
`endif
    end else if (clk_en) begin
      if (state == MUL) begin
        partial <= add_sum[CXU_DATA_W-1:0];
        mcand   <= mcand << 1;
        mplier  <= next_mplier;
`ifdef MAC_CXU_L2_SAT_EN
        ovf     <= mac_ovf;
`endif
        if (mul_done) begin
          state      <= RESP;
          resp_valid <= 1'b1;
`ifdef MAC_CXU_L2_SAT_EN
          if (mac_ovf) begin
            acc[mul_idx] <= '1;
            resp_data    <= '1;
            resp_status  <= CXU_STATUS_W'(1);
          end else begin
            acc[mul_idx] <= acc_sum[CXU_DATA_W-1:0];
            resp_data    <= acc_sum[CXU_DATA_W-1:0];
            resp_status  <= '0;
          end
`else
          acc[mul_idx] <= acc_sum[CXU_DATA_W-1:0];
          resp_data    <= acc_sum[CXU_DATA_W-1:0];
          resp_status  <= '0;
`endif
        end
      end else begin
        if (state == RESP && resp_ready) begin
          state      <= IDLE;
          resp_valid <= 1'b0;
        end
        // A new accept overrides the retire above, giving one response per cycle.
        if (accept) begin
          state       <= RESP;
          resp_valid  <= 1'b1;
          resp_status <= '0;
          if (!state_ok) begin
            resp_status <= CXU_STATUS_W'(1);
            resp_data   <= '0;
          end else begin
            case (req_func)
              CXU_FUNC_ID_W'(0): begin
                resp_data    <= acc[req_idx];
                acc[req_idx] <= '0;
              end
              CXU_FUNC_ID_W'(1): begin
                state      <= MUL;
                resp_valid <= 1'b0;
                mul_idx    <= req_idx;
                mcand      <= req_data0;
                mplier     <= req_data1;
                partial    <= '0;
`ifdef MAC_CXU_L2_SAT_EN
                ovf        <= 1'b0;
`endif
              end
              CXU_FUNC_ID_W'(2): resp_data <= acc[req_idx];
              CXU_FUNC_ID_W'(3): begin
                resp_data    <= acc[req_idx];
                acc[req_idx] <= req_data0;
              end
              default: begin
                resp_status <= CXU_STATUS_W'(1);
                resp_data   <= '0;
              end
            endcase
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_cxu_l2.sv
// tb/tb_mac_cxu_l2.sv - self-checking bench for mac_cxu_l2 against an arithmetic reference model
module tb_mac_cxu_l2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clk_en = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [0:0]  req_cxu = '0;
  logic [2:0]  req_state = '0;
  logic [9:0]  req_func = '0;
  logic [0:0]  req_insn = '0;
  logic [31:0] req_data0 = '0;
  logic [31:0] req_data1 = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [0:0]  resp_status;
  logic [31:0] resp_data;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] macc [4];

  mac_cxu_l2 #(.CXU_STATE_ID_W(3)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .req_valid(req_valid), .req_ready(req_ready), .req_cxu(req_cxu),
    .req_state(req_state), .req_func(req_func), .req_insn(req_insn),
    .req_data0(req_data0), .req_data1(req_data1),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_status(resp_status), .resp_data(resp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic on the architectural accumulators.
  task automatic model(input logic [2:0] st, input logic [9:0] fn,
                       input logic [31:0] d0, input logic [31:0] d1,
                       output logic [31:0] ed, output logic es, output int el);
    logic [63:0] full;
    int bl;
    ed = 32'd0; es = 1'b0; el = 0;
    if (st >= 3'd4 || fn > 10'd3) begin
      es = 1'b1;
    end else if (fn == 10'd0) begin
      ed = macc[st[1:0]]; macc[st[1:0]] = 32'd0;
    end else if (fn == 10'd2) begin
      ed = macc[st[1:0]];
    end else if (fn == 10'd3) begin
      ed = macc[st[1:0]]; macc[st[1:0]] = d0;
    end else begin
      bl = 0;
      for (int i = 0; i < 32; i++) if (d1[i]) bl = i + 1;
      el = (bl < 1) ? 1 : bl;
      full = {32'd0, macc[st[1:0]]} + {32'd0, d0} * {32'd0, d1};
`ifdef MAC_CXU_L2_SAT_EN
      if (full[63:32] != 32'd0) begin
        es = 1'b1; full = {32'd0, 32'hFFFF_FFFF};
      end
`endif
      macc[st[1:0]] = full[31:0];
      ed = full[31:0];
    end
  endtask

  // Entered and left just after a negedge; stall freezes clk_en right after accept.
  task automatic do_req(input string tag, input logic [2:0] st, input logic [9:0] fn,
                        input logic [31:0] d0, input logic [31:0] d1, input int stall);
    logic [31:0] ed;
    logic es;
    int el;
    int d;
    model(st, fn, d0, d1, ed, es, el);
    req_state = st; req_func = fn; req_data0 = d0; req_data1 = d1; req_valid = 1'b1;
    #1;
    chk({tag, "_ready"}, req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    if (stall > 0) clk_en = 1'b0;
    d = 0;
    while (!resp_valid && d < 200) begin
      @(negedge clk);
      d++;
      if (d == stall) clk_en = 1'b1;
    end
    clk_en = 1'b1;
    chk({tag, "_lat"}, d, el + stall);
    chk({tag, "_data"}, resp_data, ed);
    chk({tag, "_status"}, resp_status, es);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] hold;
    for (int i = 0; i < 4; i++) macc[i] = 32'd0;

    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_status", resp_status, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    do_req("wr1", 3'd1, 10'd3, 32'd7, 32'd0, 0);
    do_req("rd1", 3'd1, 10'd2, 32'd0, 32'd0, 0);
    do_req("wr0", 3'd0, 10'd3, 32'd10, 32'd0, 0);
    do_req("mac0", 3'd0, 10'd1, 32'd3, 32'd5, 0);
    do_req("rd0", 3'd0, 10'd2, 32'd0, 32'd0, 0);
    do_req("mac_z", 3'd0, 10'd1, 32'd9, 32'd0, 0);
    do_req("mac_msb", 3'd2, 10'd1, 32'd2, 32'h8000_0000, 0);
    do_req("rd2", 3'd2, 10'd2, 32'd0, 32'd0, 0);
    do_req("bad_func", 3'd1, 10'd9, 32'd55, 32'd3, 0);
    do_req("bad_state", 3'd5, 10'd3, 32'd55, 32'd3, 0);
    for (int s = 0; s < 4; s++) do_req("rd_all", 3'(s), 10'd2, 32'd0, 32'd0, 0);

    for (int n = 0; n < 40; n++)
      do_req("rand", 3'($urandom_range(0, 4)), 10'($urandom_range(0, 4)),
             $urandom, $urandom >> $urandom_range(0, 31), 0);

    // Backpressure, then four back-to-back reads retiring one per cycle.
    resp_ready = 1'b0;
    req_state = 3'd3; req_func = 10'd2; req_valid = 1'b1;
    #1;
    chk("bp_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    chk("bp_valid", resp_valid, 1'b1);
    chk("bp_data", resp_data, macc[3]);
    hold = macc[3];
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", resp_valid, 1'b1);
      chk("bp_hold_data", resp_data, hold);
      chk("bp_hold_ready", req_ready, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      resp_ready = 1'b1;
      req_state = 3'(k); req_func = 10'd2; req_valid = 1'b1;
      #1;
      chk("b2b_ready", req_ready, 1'b1);
      @(negedge clk);
      chk("b2b_valid", resp_valid, 1'b1);
      chk("b2b_data", resp_data, macc[k]);
    end
    req_valid = 1'b0;
    @(negedge clk);
    chk("b2b_drain", resp_valid, 1'b0);

    // Reset while a long MAC is in MUL.
    req_state = 3'd1; req_func = 10'd1; req_data0 = 32'd3; req_data1 = 32'hFFFF_FFFF;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_mul_valid", resp_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", req_ready, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) macc[i] = 32'd0;
    repeat (40) @(negedge clk);
    chk("abandoned_no_resp", resp_valid, 1'b0);
    for (int s = 0; s < 4; s++) do_req("rd_post_rst", 3'(s), 10'd2, 32'd0, 32'd0, 0);

    do_req("wr_stall", 3'd1, 10'd3, 32'd100, 32'd0, 0);
    do_req("mac_stall", 3'd1, 10'd1, 32'd7, 32'd5, 3);
    do_req("rd_stall", 3'd1, 10'd2, 32'd0, 32'd0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mac_cxu_l2.md
Name: mac_cxu_l2

Overview:
- Leaf CXU-L2 target; sits on one target port of the CXU-L2 switch and consumes the requests the switch forwards.
- Holds CXU_N_STATES independent DATA_W-bit accumulator states, selected per request by req_state.
- Executes accumulator functions, including a variable-latency iterative unsigned multiply-accumulate.
- Returns exactly one response per request, strictly in request order, over valid/ready handshakes.

Parameters:
- CXU_N_STATES, 4, number of accumulator states.
- CXU_STATE_ID_W, 2, request state-ID width; must be ≥ $clog2(CXU_N_STATES).
- CXU_FUNC_ID_W, 10, function ID width.
- CXU_INSN_W, 0, instruction field width; the field is ignored.
- CXU_DATA_W, 32, operand, result and accumulator width.
- CXU_STATUS_W, 1, response status width.
- CXU_CXU_ID_W, 1, CXU ID width; the field is ignored (the switch remaps it to 0).

Ports:
- clk, in, 1, clock.
- rst, in, 1, synchronous active-high reset.
- clk_en, in, 1, clock enable; when low, all state freezes.
- req_valid, in, 1, request valid.
- req_ready, out, 1, request ready.
- req_cxu, in, CXU_CXU_ID_W, ignored.
- req_state, in, CXU_STATE_ID_W, accumulator select.
- req_func, in, CXU_FUNC_ID_W, function.
- req_insn, in, max(1,CXU_INSN_W), ignored.
- req_data0, in, CXU_DATA_W, operand 0.
- req_data1, in, CXU_DATA_W, operand 1.
- resp_valid, out, 1, response valid.
- resp_ready, in, 1, response ready.
- resp_status, out, CXU_STATUS_W, 0 = OK, 1 = ERROR.
- resp_data, out, CXU_DATA_W, result.

Behaviour:
- Clocking and reset: one clock, clk; rst is synchronous, active-high.
- Reset values: state IDLE, all accumulators 0, resp_valid 0, resp_status 0, resp_data 0, req_ready 0 during the reset cycle.
- Handshake: transfer occurs when valid && ready at a clk edge with clk_en=1.
  - resp_valid/status/data are registered and held stable until the response handshake.
  - With clk_en=0, no handshake occurs and nothing changes.
- FSM states: IDLE, MUL, RESP.
- req_ready = !rst && (state==IDLE || (state==RESP && resp_ready)). This allows back-to-back requests at one per cycle.
- Functions (Acc = accumulator selected by req_state):
  - 0 CLR: Acc := 0; resp_data = old Acc.
  - 1 MAC: Acc := Acc + data0*data1, taking the low DATA_W bits; resp_data = new Acc.
  - 2 RD: resp_data = Acc.
  - 3 WR: Acc := data0; resp_data = old Acc.
  - Any other func, or req_state ≥ CXU_N_STATES: status ERROR, resp_data 0, no state change.
  - All non-MAC requests, including error responses, have 1-cycle latency: request accepted at edge N → response registered at edge N (resp_valid high in cycle N+1).
- MAC sequencing:
  - On accept: latch the state index, multiplicand = data0, multiplier = data1, partial = 0; go to MUL.
  - Each MUL cycle:
    - if multiplier[0], partial += multiplicand;
    - multiplicand <<= 1; multiplier >>= 1;
    - if the shifted multiplier == 0: Acc += partial, register the response, go to RESP.
  - MUL always runs at least one cycle.
  - Latency from accept edge to the edge registering the response is max(1, bitlen(data1)) cycles (data1 = 0 → 1; data1 = 5 → 3; data1 = 0xFFFFFFFF → 32).
- RESP state:
  - resp_ready=1: the response completes. If a new request is accepted in the same cycle, handle it as if from IDLE; otherwise go to IDLE and drop resp_valid.
  - resp_ready=0: hold the response.
- Same-state hazard: a request targeting the state just updated observes the updated value, because updates commit at or before response registration.
- Reset mid-MUL: the operation is abandoned; no response is produced.
- The accumulator is never read and written by two operations in the same cycle, since at most one request is in flight.

Optional Feature:
- Macro: MAC_CXU_L2_SAT_EN.
- Defined:
  - MAC sets a sticky overflow flag if any add into partial carries out of DATA_W, if a set bit is shifted out of the multiplicand while the multiplier is still nonzero, or if the final Acc + partial carries out.
  - On overflow, Acc := all-ones and resp_status = ERROR; resp_data = all-ones.
- Undefined: MAC wraps modulo 2^DATA_W and status is always OK for valid funcs.

Test Plan:
- Reset, then WR state1 data0=7; then RD state1 → first response data 0 status OK one cycle after accept; RD returns 7.
- WR state0 = 10, then MAC state0 data0=3 data1=5 → resp_data 25 exactly 3 cycles after accept; RD state0 = 25.
- MAC data1=0 → 1-cycle MUL, Acc unchanged, resp_data = old Acc. MAC data0=2 data1=0x80000000 → latency 32, result wraps (sat build: status ERROR, data 0xFFFFFFFF).
- req_func=9 and req_state=5 (N_STATES=4) → status ERROR, data 0, no accumulator changes.
- Hold resp_ready=0 for 5 cycles after a response → resp_valid/data stable and req_ready=0; release → back-to-back stream of 4 RD requests completes at 1 per cycle in order.
- Assert rst during MUL → no response, all accumulators read 0; clk_en=0 for 3 cycles mid-MUL → latency extends by 3, same result.
